frame_serializer: RTL and testbench

FRAME_SERIALIZER -- requirements
Module: frame_serializer

---
 rtl/serializer_pkg.sv | 17 +
 rtl/frame_fifo.sv | 64 ++++++
 rtl/frame_serializer.sv | 167 ++++++++++++++++
 tb/tb_frame_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared state encoding and counter-width helper for the frame serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Bits needed to hold 0..max_val; never narrower than one bit so GAP=0 still builds.
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Frame queue: registered storage, registered occupancy count, full/empty flags.
module frame_fifo
  import serializer_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  assign full    = (count_r == CNT_FULL);
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign rd_data = mem_r[rd_ptr_r];

  // Frame storage; contents need no reset because the count gates every read.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Queues {ADDR,DATA} frames and shifts them out one bit per DIV cycles,
// MSB- or LSB-first per frame, with GAP idle bit periods between frames.
module frame_serializer
  import serializer_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 1,
  parameter int GAP        = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA,
  input  logic              LSB_FIRST,
  input  logic              ENA,
  output logic              READY,
  output logic              OVERFLOW,
  output logic              SERIAL_OUT,
  output logic              LAST_BIT,
  output logic              BUSY
);

  localparam int FW    = ADDR_W + DATA_W;
  localparam int BIT_W = cnt_w(FW);
  localparam int DIV_W = cnt_w(DIV);
  localparam int GAP_W = cnt_w(GAP);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW);
  localparam logic [BIT_W-1:0] BIT_PEN  = BIT_W'(FW - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic GAP_EN        = (GAP > 0);
  localparam logic ONE_BIT_FRAME = (FW == 1);

  state_e           state_r;
  logic [FW-1:0]    shift_r;
  logic             lsb_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             serial_r;
  logic             last_r;
  logic             ovf_r;

  logic [FW:0]      rd_data_s;
  logic             full_s;
  logic             empty_s;
  logic             load_s;
  logic             period_end_s;
  logic [FW-1:0]    shifted_s;

  function automatic logic first_bit(input logic [FW-1:0] w, input logic lsb);
    return lsb ? w[0] : w[FW-1];
  endfunction

  frame_fifo #(.WIDTH(FW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (ENA),
    .wr_data ({LSB_FIRST, ADDR, DATA}),
    .rd_en   (load_s),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign period_end_s = (div_cnt_r == DIV_LAST);
  assign READY        = ~full_s;
  assign OVERFLOW     = ovf_r;
  assign SERIAL_OUT   = serial_r;
  assign LAST_BIT     = last_r;
  assign BUSY         = ~empty_s | (state_r != ST_IDLE);

  // Decide whether a queued frame is pulled into the shift register this cycle.
  always_comb begin
    load_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = ~empty_s;
      ST_SEND: load_s = ~GAP_EN & period_end_s & (bit_cnt_r == BIT_LAST) & ~empty_s;
      ST_GAP:  load_s = period_end_s & (gap_cnt_r == GAP_LAST) & ~empty_s;
      default: load_s = 1'b0;
    endcase
  end

  // Next shift-register contents after the current bit has been sent.
  always_comb begin
    if (lsb_r) begin
      shifted_s = shift_r >> 1'b1;
    end else begin
      shifted_s = shift_r << 1'b1;
    end
  end

  // Serializer state machine with registered SERIAL_OUT, LAST_BIT and OVERFLOW.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      shift_r   <= {FW{1'b0}};
      lsb_r     <= 1'b0;
      bit_cnt_r <= {BIT_W{1'b0}};
      div_cnt_r <= {DIV_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      serial_r  <= 1'b0;
      last_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      ovf_r <= ENA & full_s;
      if (load_s) begin
        state_r   <= ST_SEND;
        shift_r   <= rd_data_s[FW-1:0];
        lsb_r     <= rd_data_s[FW];
        serial_r  <= first_bit(rd_data_s[FW-1:0], rd_data_s[FW]);
        last_r    <= ONE_BIT_FRAME;
        bit_cnt_r <= BIT_W'(1);
        div_cnt_r <= {DIV_W{1'b0}};
        gap_cnt_r <= {GAP_W{1'b0}};
      end else begin
        case (state_r)
          ST_SEND: begin
            if (!period_end_s) begin
              div_cnt_r <= div_cnt_r + 1'b1;
            end else begin
              div_cnt_r <= {DIV_W{1'b0}};
              if (bit_cnt_r == BIT_LAST) begin
                shift_r   <= {FW{1'b0}};
                serial_r  <= 1'b0;
                last_r    <= 1'b0;
                bit_cnt_r <= {BIT_W{1'b0}};
                state_r   <= GAP_EN ? ST_GAP : ST_IDLE;
              end else begin
                shift_r   <= shifted_s;
                serial_r  <= first_bit(shifted_s, lsb_r);
                bit_cnt_r <= bit_cnt_r + 1'b1;
                last_r    <= (bit_cnt_r == BIT_PEN);
              end
            end
          end
          ST_GAP: begin
            serial_r <= 1'b0;
            if (!period_end_s) begin
              div_cnt_r <= div_cnt_r + 1'b1;
            end else begin
              div_cnt_r <= {DIV_W{1'b0}};
              if (gap_cnt_r == GAP_LAST) begin
                gap_cnt_r <= {GAP_W{1'b0}};
                state_r   <= ST_IDLE;
              end else begin
                gap_cnt_r <= gap_cnt_r + 1'b1;
              end
            end
          end
          ST_IDLE: begin
            state_r  <= ST_IDLE;
            serial_r <= 1'b0;
          end
          default: begin
            state_r  <= ST_IDLE;
            serial_r <= 1'b0;
            last_r   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: three parameter sets share one stimulus stream and are
// compared every cycle with a frame-schedule reference model.
`timescale 1ns/1ps
module tb_frame_serializer;

  localparam int NDUT  = 3;
  localparam int FW    = 19;
  localparam int DEPTH = 4;
  localparam int DIVS [NDUT] = '{1, 3, 1};
  localparam int GAPS [NDUT] = '{1, 1, 0};
  localparam logic [4:0] RST_VEC = 5'b00010;  // {so,last,busy,ready,ovf}

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  ADDR;
  logic [15:0] DATA;
  logic        LSB_FIRST;
  logic        ENA;
  logic [NDUT-1:0] ready_w, ovf_w, so_w, last_w, busy_w;

  frame_serializer dut0 (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA(DATA), .LSB_FIRST(LSB_FIRST), .ENA(ENA),
    .READY(ready_w[0]), .OVERFLOW(ovf_w[0]), .SERIAL_OUT(so_w[0]),
    .LAST_BIT(last_w[0]), .BUSY(busy_w[0]));

  frame_serializer #(.DIV(3)) dut1 (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA(DATA), .LSB_FIRST(LSB_FIRST), .ENA(ENA),
    .READY(ready_w[1]), .OVERFLOW(ovf_w[1]), .SERIAL_OUT(so_w[1]),
    .LAST_BIT(last_w[1]), .BUSY(busy_w[1]));

  frame_serializer #(.GAP(0)) dut2 (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA(DATA), .LSB_FIRST(LSB_FIRST), .ENA(ENA),
    .READY(ready_w[2]), .OVERFLOW(ovf_w[2]), .SERIAL_OUT(so_w[2]),
    .LAST_BIT(last_w[2]), .BUSY(busy_w[2]));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: queued frames and the schedule of the frame on the wire.
  logic [FW:0] mq [NDUT][$];
  logic [FW:0] cur [NDUT];
  logic        hcur [NDUT];
  int          cstart [NDUT];
  int          nfree [NDUT];
  logic [4:0]  exp_v [NDUT];

  function automatic logic [4:0] obs(input int d);
    return {so_w[d], last_w[d], busy_w[d], ready_w[d], ovf_w[d]};
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < NDUT; d++) begin
      mq[d].delete();
      hcur[d]   = 1'b0;
      cstart[d] = 0;
      nfree[d]  = 0;
      exp_v[d]  = RST_VEC;
    end
  endfunction

  // Drive one cycle, then advance the model: a frame starts when something is queued
  // and the previous frame plus its gap has elapsed; a write lands only if not full.
  task automatic tick(input logic en, input logic [2:0] a, input logic [15:0] dd, input logic lsb);
    logic full, ov, so, lst, busy;
    int k;
    ENA = en; ADDR = a; DATA = dd; LSB_FIRST = lsb;
    @(posedge CLK);
    #1;
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      full = (mq[d].size() == DEPTH);
      ov   = en && full;
      if (mq[d].size() > 0 && cyc >= nfree[d]) begin
        cur[d]    = mq[d].pop_front();
        hcur[d]   = 1'b1;
        cstart[d] = cyc;
        nfree[d]  = cyc + (FW + GAPS[d]) * DIVS[d];
      end
      if (en && !full) mq[d].push_back({lsb, a, dd});
      so = 1'b0; lst = 1'b0;
      if (hcur[d] && (cyc - cstart[d]) < FW * DIVS[d]) begin
        k   = (cyc - cstart[d]) / DIVS[d];
        so  = cur[d][FW] ? cur[d][k] : cur[d][FW-1-k];
        lst = (k == FW - 1);
      end
      busy = (mq[d].size() > 0) || (hcur[d] && cyc < cstart[d] + (FW + GAPS[d]) * DIVS[d]);
      exp_v[d] = {so, lst, busy, (mq[d].size() < DEPTH), ov};
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; ENA = 1'b0; ADDR = 3'd0; DATA = 16'd0; LSB_FIRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (obs(d) !== RST_VEC) begin
        n_fail++;
        $display("FAIL reset d%0d: got %b expected %b", d, obs(d), RST_VEC);
      end
    end
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
  endtask

  task automatic test_single(input logic lsb);
    logic [FW-1:0]   word, got0, want0;
    logic [3*FW-1:0] got1, want1;
    int last0, last1, busy0, busy1;
    word = {3'b101, 16'hA5C3};
    got0 = '0; got1 = '0; last0 = 0; last1 = 0; busy0 = 0; busy1 = 0;
    for (int t = 0; t < 70; t++) begin
      if (t == 0) tick(1'b1, 3'b101, 16'hA5C3, lsb);
      else tick(1'b0, 3'($urandom()), 16'($urandom()), 1'($urandom()));
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_fail++;
          $display("FAIL single d%0d cyc %0d: got so/last/busy/rdy/ovf=%b expected %b", d, cyc, obs(d), exp_v[d]);
        end
      end
      if (t >= 1 && t <= FW) got0 = {got0[FW-2:0], so_w[0]};
      if (t >= 1 && t <= 3*FW) got1 = {got1[3*FW-2:0], so_w[1]};
      last0 += int'(last_w[0]); last1 += int'(last_w[1]);
      busy0 += int'(busy_w[0]); busy1 += int'(busy_w[1]);
    end
    for (int k = 0; k < FW; k++) begin
      want0[FW-1-k] = lsb ? word[k] : word[FW-1-k];
      for (int r = 0; r < 3; r++) want1[3*FW-1-(3*k+r)] = lsb ? word[k] : word[FW-1-k];
    end
    n_checks += 6;
    if (!lsb && got0 !== 19'b1011010010111000011) begin
      n_fail++; $display("FAIL single_msb_stream: got %b expected 1011010010111000011", got0);
    end
    if (got0 !== want0) begin n_fail++; $display("FAIL single_stream_d0: got %b expected %b", got0, want0); end
    if (got1 !== want1) begin n_fail++; $display("FAIL single_stream_d1: got %h expected %h", got1, want1); end
    if (last0 != 1 || last1 != 3) begin
      n_fail++; $display("FAIL single_last_len: got %0d/%0d expected 1/3", last0, last1);
    end
    if (busy0 != 21) begin n_fail++; $display("FAIL single_busy_d0: got %0d expected 21", busy0); end
    if (busy1 != 61) begin n_fail++; $display("FAIL single_busy_d1: got %0d expected 61", busy1); end
  endtask

  task automatic test_back_to_back();
    int ovf_cnt [NDUT];
    int frames [NDUT];
    logic [NDUT-1:0] prev_last;
    prev_last = '0;
    for (int d = 0; d < NDUT; d++) begin ovf_cnt[d] = 0; frames[d] = 0; end
    for (int t = 0; t < 330; t++) begin
      tick(t < 6, 3'($urandom()), 16'($urandom()), 1'($urandom()));
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_fail++;
          $display("FAIL b2b d%0d cyc %0d: got so/last/busy/rdy/ovf=%b expected %b", d, cyc, obs(d), exp_v[d]);
        end
        ovf_cnt[d] += int'(ovf_w[d]);
        if (last_w[d] && !prev_last[d]) frames[d]++;
      end
      prev_last = last_w;
    end
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (ovf_cnt[d] != 1 || frames[d] != 5) begin
        n_fail++;
        $display("FAIL b2b_counts d%0d: got ovf=%0d frames=%0d expected ovf=1 frames=5", d, ovf_cnt[d], frames[d]);
      end
    end
  endtask

  task automatic test_gap_zero();
    logic [2*FW-1:0] got, want;
    want = {3'b101, 16'hA5C3, 3'b010, 16'h0F0F};
    got  = '0;
    for (int t = 0; t < 130; t++) begin
      if (t == 0) tick(1'b1, 3'b101, 16'hA5C3, 1'b0);
      else if (t == 1) tick(1'b1, 3'b010, 16'h0F0F, 1'b0);
      else tick(1'b0, 3'($urandom()), 16'($urandom()), 1'($urandom()));
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_fail++;
          $display("FAIL gap0 d%0d cyc %0d: got so/last/busy/rdy/ovf=%b expected %b", d, cyc, obs(d), exp_v[d]);
        end
      end
      if (t >= 1 && t <= 2*FW) got = {got[2*FW-2:0], so_w[2]};
    end
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL gap0_stream: got %h expected %h", got, want); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 720; t++) begin
      tick((t < 400) && ($urandom_range(0, 99) < 35), 3'($urandom()), 16'($urandom()), 1'($urandom()));
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_fail++;
          $display("FAIL random d%0d cyc %0d: got so/last/busy/rdy/ovf=%b expected %b", d, cyc, obs(d), exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    for (int t = 0; t < 9; t++) begin
      tick(t < 3, 3'($urandom()), 16'($urandom()), 1'b0);
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_fail++;
          $display("FAIL mid_pre d%0d cyc %0d: got so/last/busy/rdy/ovf=%b expected %b", d, cyc, obs(d), exp_v[d]);
        end
      end
    end
    #3;
    RST = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (obs(d) !== RST_VEC) begin
        n_fail++; $display("FAIL mid_async d%0d: got %b expected %b", d, obs(d), RST_VEC);
      end
    end
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (obs(d) !== RST_VEC) begin
        n_fail++; $display("FAIL mid_held d%0d: got %b expected %b", d, obs(d), RST_VEC);
      end
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int t = 0; t < 80; t++) begin
      tick(1'b0, 3'($urandom()), 16'($urandom()), 1'($urandom()));
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_fail++;
          $display("FAIL mid_post d%0d cyc %0d: got so/last/busy/rdy/ovf=%b expected %b", d, cyc, obs(d), exp_v[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back();
    test_gap_zero();
    test_random();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
